// File: rtl/cond_ctrl_pipe_pkg.sv
// Shared definitions for the Execute-stage control pipeline: ARM condition codes,
// NZCV bit positions, ALU op encodings and the per-stage control bundles.
package cond_ctrl_pipe_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // A flushed slot carries AL so it never looks like a failed predicate.
    localparam logic [3:0] COND_BUBBLE = COND_AL;

    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [1:0] alu_control;
        logic       branch;
        logic [1:0] alu_src;
        logic [1:0] flag_write;
        logic [3:0] cond;
    } ex_ctrl_t;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    localparam ex_ctrl_t EX_RESET = '{
        pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
        alu_control: 2'b00, branch: 1'b0, alu_src: 2'b00,
        flag_write: 2'b00, cond: 4'b0000
    };

    localparam ex_ctrl_t EX_BUBBLE = '{
        pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
        alu_control: 2'b00, branch: 1'b0, alu_src: 2'b00,
        flag_write: 2'b00, cond: COND_BUBBLE
    };

endpackage

// File: rtl/cond_ctrl_pipe_cond_check.sv
// Combinational ARM condition-field evaluator: condition code + NZCV -> pass/fail.
// Kept standalone so predication or forwarding logic can reuse it.
module cond_check
    import cond_ctrl_pipe_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output
        // unassigned; an unassigned path in always_comb infers a latch.
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = !z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = !c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = !n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = !v;
            COND_HI: cond_ex_o = c & !z;
            COND_LS: cond_ex_o = !c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = !z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b0;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// Execute/Memory/Writeback control pipeline: registers decode control, evaluates the
// condition field against the NZCV register, updates flags and gates side effects.
module cond_ctrl_pipe
    import cond_ctrl_pipe_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemWriteD,
    input  logic [1:0] ALUControlD,
    input  logic       BranchD,
    input  logic [1:0] ALUSrcD,
    input  logic [1:0] FlagWriteD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlagsE,
    input  logic       FlushE,

    output logic [1:0] ALUControlE,
    output logic [1:0] ALUSrcE,
    output logic [3:0] FlagsE,
    output logic       CondExE,
    output logic       BranchTakenE,

    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemtoRegM,
    output logic       MemWriteM,

    output logic       PCSrcW,
    output logic       RegWriteW,
    output logic       MemtoRegW
);

    ex_ctrl_t  ex_d,    ex_q;
    mem_ctrl_t mem_d,   mem_q;
    wb_ctrl_t  wb_d,    wb_q;
    logic [3:0] flags_d, flags_q;
    logic       cond_ex;

    cond_check u_cond_check (
        .cond_i    (ex_q.cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    always_comb begin
        ex_d = EX_BUBBLE;
        if (!FlushE) begin
            ex_d.pcsrc       = PCSrcD;
            ex_d.regwrite    = RegWriteD;
            ex_d.memtoreg    = MemtoRegD;
            ex_d.memwrite    = MemWriteD;
            ex_d.alu_control = ALUControlD;
            ex_d.branch      = BranchD;
            ex_d.alu_src     = ALUSrcD;
            ex_d.flag_write  = FlagWriteD;
            ex_d.cond        = CondD;
        end
    end

    // The instruction in Execute commits its flag halves even when FlushE is
    // bubbling the slot behind it.
    always_comb begin
        flags_d = flags_q;
        if (ex_q.flag_write[1] && cond_ex) begin
            flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
            flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
        end
        if (ex_q.flag_write[0] && cond_ex) begin
            flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
            flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
        end
    end

    always_comb begin
        mem_d.pcsrc    = ex_q.pcsrc & !ex_q.branch & cond_ex;
        mem_d.regwrite = ex_q.regwrite & cond_ex;
        mem_d.memtoreg = ex_q.memtoreg;
        mem_d.memwrite = ex_q.memwrite & cond_ex;

        wb_d.pcsrc     = mem_q.pcsrc;
        wb_d.regwrite  = mem_q.regwrite;
        wb_d.memtoreg  = mem_q.memtoreg;
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of the stage before it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= EX_RESET;
            flags_q <= RESET_FLAGS;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            ex_q    <= ex_d;
            flags_q <= flags_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign ALUControlE  = ex_q.alu_control;
    assign ALUSrcE      = ex_q.alu_src;
    assign FlagsE       = flags_q;
    assign CondExE      = cond_ex;
    assign BranchTakenE = ex_q.branch & cond_ex;

    assign PCSrcM       = mem_q.pcsrc;
    assign RegWriteM    = mem_q.regwrite;
    assign MemtoRegM    = mem_q.memtoreg;
    assign MemWriteM    = mem_q.memwrite;

    assign PCSrcW       = wb_q.pcsrc;
    assign RegWriteW    = wb_q.regwrite;
    assign MemtoRegW    = wb_q.memtoreg;

endmodule
